// File: rtl/param_frame_loader_if.sv
// Byte-stream handshake into the parameter/activation frame loader.
// Master drives bytes, slave signals when it can take one.
interface param_frame_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/param_frame_loader.sv
// Framed byte loader: assembles parameter or activation frames in a
// shadow register and commits them atomically to the classifier buses.
module param_frame_loader #(
  parameter int          PARAM_BYTES = 52,
  parameter int          ACT_BYTES   = 6,
  parameter logic [7:0]  HDR_PARAM   = 8'hA5,
  parameter logic [7:0]  HDR_ACT     = 8'h5A
) (
  input  logic          clk,
  input  logic          rst,
  param_frame_loader_if.slave stream,
  output logic [87:0]   weights2,
  output logic [263:0]  weights6,
  output logic [15:0]   bias2,
  output logic [47:0]   bias6,
  output logic [43:0]   activations,
  output logic          load_params,
  output logic          act_valid,
  output logic          busy,
  output logic          err
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] PARAM    = 3'd1;
  localparam logic [2:0] ACT      = 3'd2;
  localparam logic [2:0] COMMIT_P = 3'd3;
  localparam logic [2:0] COMMIT_A = 3'd4;

  localparam logic [5:0] P_LAST = 6'(PARAM_BYTES - 1);
  localparam logic [5:0] A_LAST = 6'(ACT_BYTES - 1);

  logic [2:0]                 state;
  logic [5:0]                 cnt;
  logic [8*PARAM_BYTES-1:0]   pshadow;
  logic [8*ACT_BYTES-1:0]     ashadow;
  logic                       take;
  logic                       loading;
  logic                       unused_ashadow;

  assign loading = (state == IDLE) ||
                   (state == PARAM) ||
                   (state == ACT);

  // Ready is forced low while reset is held.
  assign stream.in_ready = !rst && loading;
  assign take            = stream.in_valid && stream.in_ready;
  assign busy            = (state != IDLE);

  // Top nibble of the activation frame is padding.
  assign unused_ashadow = ^ashadow[8*ACT_BYTES-1:44];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      pshadow     <= '0;
      ashadow     <= '0;
      weights2    <= '0;
      weights6    <= '0;
      bias2       <= '0;
      bias6       <= '0;
      activations <= '0;
      load_params <= 1'b0;
      act_valid   <= 1'b0;
      err         <= 1'b0;
    end else begin
      load_params <= 1'b0;
      act_valid   <= 1'b0;
      err         <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            if (stream.in_data == HDR_PARAM) begin
              state <= PARAM;
              cnt   <= '0;
            end else if (stream.in_data == HDR_ACT) begin
              state <= ACT;
              cnt   <= '0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        PARAM: begin
          if (take) begin
            pshadow[{cnt, 3'b000} +: 8] <= stream.in_data;
            cnt <= cnt + 6'd1;
            if (cnt == P_LAST) begin
              state <= COMMIT_P;
            end
          end
        end
        ACT: begin
          if (take) begin
            ashadow[{cnt[2:0], 3'b000} +: 8] <= stream.in_data;
            cnt <= cnt + 6'd1;
            if (cnt == A_LAST) begin
              state <= COMMIT_A;
            end
          end
        end
        COMMIT_P: begin
          weights2    <= pshadow[87:0];
          weights6    <= pshadow[351:88];
          bias2       <= pshadow[367:352];
          bias6       <= pshadow[415:368];
          load_params <= 1'b1;
          state       <= IDLE;
        end
        COMMIT_A: begin
          activations <= ashadow[43:0];
          act_valid   <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
